median3_seq_sched: RTL and testbench
====================================

Name: median3_seq_sched

Overview:
- Sequential scheduler that time-shares one 32-bit compare-exchange unit to sort three unsigned words, using the 3-stage bubble schedule (0,1) → (1,2) → (0,1).
- Replaces the three parallel comparators of the combinational 3-input sorter where area matters more than throughput.
- Sits between a valid/ready sample producer and a valid/ready consumer.
- Emits all three sorted words, with sort_1 as the median.

Parameters:
- DATA_W, 32, width of each data word (unsigned compare).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer has a triple on data_0..data_2.
- in_ready  out  1  block accepts a triple this cycle.
- data_0  in  DATA_W  input word 0.
- data_1  in  DATA_W  input word 1.
- data_2  in  DATA_W  input word 2.
- out_valid  out  1  sort_0..sort_2 hold a finished result.
- out_ready  in  1  consumer takes the result this cycle.
- sort_0  out  DATA_W  smallest word.
- sort_1  out  DATA_W  median word.
- sort_2  out  DATA_W  largest word.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: FSM=IDLE; working registers r0, r1, r2 = 0; out_valid=0; busy=0. in_ready=1 once rst_n deasserts.
- FSM states: IDLE, CX01A, CX12, CX01B, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: r0..r2 ← data_0..data_2, next state CX01A.
- CX01A: if r0 > r1, swap r0/r1. Next state CX12.
- CX12: if r1 > r2, swap r1/r2. Next state CX01B.
- CX01B: if r0 > r1, swap r0/r1. Next state DONE.
- Compare-exchange rules:
  - A single shared comparator is muxed by state. No other magnitude comparator exists.
  - Compare is unsigned, strict ">". Equal values are not swapped.
- DONE:
  - out_valid=1; sort_0..sort_2 = r0..r2.
  - Outputs stay stable while out_ready=0.
  - On out_ready with in_valid=0: next state IDLE.
- Back-to-back operation:
  - In DONE, in_ready = out_ready.
  - If out_ready and in_valid are both 1: result retires, new triple loads, next state CX01A.
  - Sustained throughput is 1 triple per 4 cycles.
- Latency: accept edge E0 → out_valid=1 after edge E3 (3 compare cycles).
- in_ready=0 in CX01A, CX12 and CX01B. Input changes in those states are ignored.
- sort_0..sort_2 always mirror r0..r2. Consumers qualify them with out_valid only.
- busy=1 in every state except IDLE.
- Reset mid-operation: immediate return to reset values. The partial result is discarded, with no out_valid pulse.
- Illegal state encoding: recovers to IDLE on the next edge.

Optional Feature:
- Macro: MEDIAN3_SEQ_CNT_EN.
- Defined:
  - Adds output port done_cnt, 16 bits.
  - Increments on each out_valid && out_ready handshake and wraps 0xFFFF→0x0000.
  - Reset to 0 by rst_n.
- Undefined: port absent, no counter logic. Functional behaviour is otherwise identical.

Test Plan:
- Reset then single triple:
  - Stimulus: rst_n low 3 cycles, then data=(30,10,20), in_valid 1 cycle, out_ready=1.
  - Required: out_valid rises exactly 3 edges after accept; sort=(10,20,30); busy falls the cycle after handshake.
- Reverse order and ties:
  - Stimulus: triples (0xFFFFFFFF,5,0) and (7,7,3).
  - Required: sort=(0,5,0xFFFFFFFF), then sort=(3,7,7); unsigned compare confirmed.
- Consumer backpressure:
  - Stimulus: data=(9,1,4), out_ready=0 for 5 cycles.
  - Required: out_valid stays 1, sort=(1,4,9) stable, in_ready=0. Raising out_ready then gives one handshake, back to IDLE.
- Back-to-back stream:
  - Stimulus: 100 random triples, in_valid and out_ready held 1.
  - Required: one result every 4 cycles; each result is sorted and is the permutation of its input triple.
- Reset mid-sort:
  - Stimulus: drop rst_n during CX12.
  - Required: out_valid=0 and busy=0 immediately; next triple (2,3,1) sorts to (1,2,3) normally.
- Counter (MEDIAN3_SEQ_CNT_EN defined):
  - Stimulus: 65537 handshakes.
  - Required: done_cnt reads 1 after wrap.

Source files
------------

// File: rtl/median3_seq_sched.sv
// Sorts three unsigned words over three cycles using one shared compare-exchange unit.
// Optional completion counter (done_cnt) is enabled by defining MEDIAN3_SEQ_CNT_EN.
module median3_seq_sched #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_0,
    input  logic [DATA_W-1:0] data_1,
    input  logic [DATA_W-1:0] data_2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] sort_0,
    output logic [DATA_W-1:0] sort_1,
    output logic [DATA_W-1:0] sort_2,
    output logic              busy
`ifdef MEDIAN3_SEQ_CNT_EN
    ,
    output logic [15:0]       done_cnt
`endif
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CX01A = 3'd1;
    localparam logic [2:0] CX12  = 3'd2;
    localparam logic [2:0] CX01B = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [DATA_W-1:0] r0, r1, r2;
    logic [DATA_W-1:0] cmp_a, cmp_b;
    logic              cmp_gt;
    logic              accept;
    logic              retire;

    // The one magnitude comparator; CX12 looks at (r1,r2), the other stages at (r0,r1).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        cmp_a = r0;
        cmp_b = r1;
        if (state == CX12) begin
            cmp_a = r1;
            cmp_b = r2;
        end
    end

    assign cmp_gt = cmp_a > cmp_b;

    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign in_ready  = rst_n && ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign retire    = out_valid && out_ready;

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = accept ? CX01A : IDLE;
            CX01A:   state_nxt = CX12;
            CX12:    state_nxt = CX01B;
            CX01B:   state_nxt = DONE;
            DONE: begin
                if (!out_ready)
                    state_nxt = DONE;
                else if (in_valid)
                    state_nxt = CX01A;
                else
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state is always assigned with non-blocking (<=) assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Working registers: load on accept, otherwise conditionally swap the pair under compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0 <= '0;
            r1 <= '0;
            r2 <= '0;
        end else if (accept) begin
            r0 <= data_0;
            r1 <= data_1;
            r2 <= data_2;
        end else begin
            case (state)
                CX01A, CX01B: begin
                    if (cmp_gt) begin
                        r0 <= r1;
                        r1 <= r0;
                    end
                end
                CX12: begin
                    if (cmp_gt) begin
                        r1 <= r2;
                        r2 <= r1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sort_0 = r0;
    assign sort_1 = r1;
    assign sort_2 = r2;

`ifdef MEDIAN3_SEQ_CNT_EN
    // Counts retired results; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            done_cnt <= '0;
        else if (retire)
            done_cnt <= done_cnt + 16'd1;
    end
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_median3_seq_sched.sv
// Self-checking bench for median3_seq_sched: a transaction-level model (accept, wait
// three compare cycles, present the min/median/max) is checked every cycle, plus directed literals.
module tb_median3_seq_sched;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_0, data_1, data_2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sort_0, sort_1, sort_2;
    logic        busy;
`ifdef MEDIAN3_SEQ_CNT_EN
    logic [15:0] done_cnt;
`endif

    median3_seq_sched #(.DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_0    (data_0),
        .data_1    (data_1),
        .data_2    (data_2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sort_0    (sort_0),
        .sort_1    (sort_1),
        .sort_2    (sort_2),
        .busy      (busy)
`ifdef MEDIAN3_SEQ_CNT_EN
        ,
        .done_cnt  (done_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] min3(input logic [31:0] a, b, c);
        logic [31:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic [31:0] max3(input logic [31:0] a, b, c);
        logic [31:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic [31:0] mid3(input logic [31:0] a, b, c);
        logic [33:0] s;
        s = 34'(a) + 34'(b) + 34'(c) - 34'(min3(a, b, c)) - 34'(max3(a, b, c));
        return s[31:0];
    endfunction

    // Transaction model: a job becomes visible three edges after it is accepted.
    logic        m_job;
    int          m_age;
    logic [31:0] m_s0, m_s1, m_s2;
    logic [15:0] m_cnt;
    logic        m_valid;
    logic        m_rdy;

    assign m_valid = m_job && (m_age >= 3);
    assign m_rdy   = !m_job || (m_valid && out_ready);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_job <= 1'b0;
            m_age <= 0;
            m_cnt <= '0;
        end else begin
            if (in_valid && m_rdy) begin
                m_job <= 1'b1;
                m_age <= 0;
                m_s0  <= min3(data_0, data_1, data_2);
                m_s1  <= mid3(data_0, data_1, data_2);
                m_s2  <= max3(data_0, data_1, data_2);
            end else if (m_valid && out_ready) begin
                m_job <= 1'b0;
            end else if (m_job && m_age < 3) begin
                m_age <= m_age + 1;
            end
            if (m_valid && out_ready)
                m_cnt <= m_cnt + 16'd1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid", out_valid, m_valid);
            check("busy", busy, m_job);
            check("in_ready", in_ready, m_rdy);
            if (m_valid) begin
                check("model_sort_0", sort_0, m_s0);
                check("model_sort_1", sort_1, m_s1);
                check("model_sort_2", sort_2, m_s2);
            end
`ifdef MEDIAN3_SEQ_CNT_EN
            check("done_cnt", done_cnt, m_cnt);
`endif
        end
    end

    // Handshake spacing during the streaming phase.
    logic bb_mode = 1'b0;
    int   cyc     = 0;
    int   last_hs = -1;
    int   bb_hs   = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!bb_mode) begin
            last_hs <= -1;
        end else if (out_valid && out_ready) begin
            if (last_hs >= 0)
                check("bb_interval", 64'(cyc - last_hs), 64'd4);
            last_hs <= cyc;
            bb_hs   <= bb_hs + 1;
        end
    end

    task automatic wait_valid(output int lat);
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!out_valid)
            check("wait_out_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic send(input logic [31:0] a, b, c);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        data_0   = a;
        data_1   = b;
        data_2   = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_triple(input logic [31:0] a, b, c, e0, e1, e2);
        int lat;
        send(a, b, c);
        wait_valid(lat);
        check("latency", 64'(lat), 64'd3);
        check("lit_sort_0", sort_0, e0);
        check("lit_sort_1", sort_1, e1);
        check("lit_sort_2", sort_2, e2);
        @(posedge clk);
        @(negedge clk);
        check("idle_after_hs_busy", busy, 1'b0);
        check("idle_after_hs_valid", out_valid, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        data_0    = '0;
        data_1    = '0;
        data_2    = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sort_1", sort_1, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);

        run_triple(32'd30, 32'd10, 32'd20, 32'd10, 32'd20, 32'd30);
        run_triple(32'hFFFF_FFFF, 32'd5, 32'd0, 32'd0, 32'd5, 32'hFFFF_FFFF);
        run_triple(32'd7, 32'd7, 32'd3, 32'd3, 32'd7, 32'd7);

        // Consumer backpressure
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(32'd9, 32'd1, 32'd4);
        wait_valid(lat);
        check("bp_latency", 64'(lat), 64'd3);
        repeat (5) begin
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_sort_0", sort_0, 32'd1);
            check("bp_sort_1", sort_1, 32'd4);
            check("bp_sort_2", sort_2, 32'd9);
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("bp_done_valid", out_valid, 1'b0);
        check("bp_done_busy", busy, 1'b0);

        // Back-to-back stream
        @(posedge clk);
        #1;
        bb_mode  = 1'b1;
        in_valid = 1'b1;
        data_0   = $urandom;
        data_1   = $urandom;
        data_2   = $urandom;
        for (int i = 0; i < 1000 && bb_hs < 100; i++) begin
            @(posedge clk);
            #1;
            data_0 = $urandom;
            data_1 = $urandom_range(0, 15);
            data_2 = (i % 7 == 0) ? data_0 : $urandom;
        end
        check("bb_handshakes", 64'(bb_hs >= 100), 64'd1);
        in_valid = 1'b0;
        bb_mode  = 1'b0;
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        check("bb_drained", busy, 1'b0);

        // Reset during CX12
        send(32'd5, 32'd6, 32'd4);
        @(posedge clk);
        #1;
        check("mid_busy_before", busy, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_triple(32'd2, 32'd3, 32'd1, 32'd1, 32'd2, 32'd3);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
